// File: rtl/bsg_wormhole_endpoint_header_splitter.sv
// Wormhole endpoint header splitter.
// Takes flits from an input fifo. The header flit of each packet is held in a one-deep register
// for the consumer's control logic. Payload flits pass straight through a valid/ready port, and
// the final payload flit of each packet is marked. Packet boundaries come from the header's
// length field (flit[cord_width_p +: len_width_p] = number of payload flits).
// Optional build macro BSG_WORMHOLE_HEADER_SPLITTER_STATS_EN adds these two items:
//  - a 16-bit completed-packet counter on pkt_count_o
//  - a check that header_yumi_i never asserts without a held header.
module bsg_wormhole_endpoint_header_splitter #(
  parameter int unsigned flit_width_p = 32,
  parameter int unsigned cord_width_p = 5,
  parameter int unsigned len_width_p  = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    fifo_v_i,
  input  logic [flit_width_p-1:0] fifo_data_i,
  output logic                    fifo_yumi_o,
  output logic                    header_v_o,
  output logic [flit_width_p-1:0] header_o,
  input  logic                    header_yumi_i,
  output logic                    data_v_o,
  output logic [flit_width_p-1:0] data_o,
  output logic                    data_last_o,
  input  logic                    data_ready_and_i
`ifdef BSG_WORMHOLE_HEADER_SPLITTER_STATS_EN
  ,
  output logic [15:0]             pkt_count_o
`endif
);

  typedef enum logic [0:0] {StHdr, StData} state_e;

  state_e                  state_r;
  logic                    hdr_v_r;
  logic [len_width_p-1:0]  cnt_r;
  logic [flit_width_p-1:0] header_r;

  logic [len_width_p-1:0]  fifo_len;
  logic                    hdr_deq;
  logic                    data_deq;
  logic                    cnt_is_one;

  // Decode the dequeue condition for each state; all outputs are held quiet during reset.
  always_comb begin
    fifo_len   = fifo_data_i[cord_width_p +: len_width_p];
    cnt_is_one = (cnt_r == len_width_p'(1));
    // A new header may be captured only when the register is empty or drains this same cycle.
    hdr_deq    = reset_n_i & (state_r == StHdr) & fifo_v_i & (~hdr_v_r | header_yumi_i);
    data_deq   = reset_n_i & (state_r == StData) & fifo_v_i & data_ready_and_i;

    fifo_yumi_o = hdr_deq | data_deq;
    header_v_o  = hdr_v_r;
    header_o    = header_r;
    data_v_o    = reset_n_i & (state_r == StData) & fifo_v_i;
    data_o      = fifo_data_i;
    data_last_o = data_v_o & cnt_is_one;
  end

  // Packet parser FSM, header register and remaining-payload counter.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r  <= StHdr;
      hdr_v_r  <= 1'b0;
      cnt_r    <= '0;
      header_r <= '0;
    end else begin
      if (hdr_deq) begin
        header_r <= fifo_data_i;
        hdr_v_r  <= 1'b1;
        cnt_r    <= fifo_len;
        state_r  <= (fifo_len == '0) ? StHdr : StData;
      end else if (header_yumi_i) begin
        hdr_v_r <= 1'b0;
      end

      if (data_deq) begin
        cnt_r <= cnt_r - len_width_p'(1);
        if (cnt_is_one) begin
          state_r <= StHdr;
        end
      end
    end
  end

`ifdef BSG_WORMHOLE_HEADER_SPLITTER_STATS_EN
  logic [15:0] pkt_count_r;
  logic        pkt_done;

  // A packet completes on its last payload flit, or on its header when it has no payload.
  always_comb begin
    pkt_done    = (hdr_deq & (fifo_len == '0)) | (data_deq & cnt_is_one);
    pkt_count_o = pkt_count_r;
  end

  // Free-running completed-packet counter; wraps naturally.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pkt_count_r <= '0;
    end else if (pkt_done) begin
      pkt_count_r <= pkt_count_r + 16'd1;
    end
  end

  // Consumer must not take a header that is not there.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(header_yumi_i && !hdr_v_r))
        else $error("header_yumi_i asserted with no header held");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_wormhole_endpoint_header_splitter.sv
// Directed self-checking bench for bsg_wormhole_endpoint_header_splitter.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later, mid-cycle.
module tb_bsg_wormhole_endpoint_header_splitter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fifo_v;
  logic [31:0] fifo_data;
  logic        fifo_yumi;
  logic        header_v;
  logic [31:0] header;
  logic        header_yumi;
  logic        data_v;
  logic [31:0] data;
  logic        data_last;
  logic        data_ready;
`ifdef BSG_WORMHOLE_HEADER_SPLITTER_STATS_EN
  logic [15:0] pkt_count;
`endif

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_wormhole_endpoint_header_splitter #(
    .flit_width_p(32),
    .cord_width_p(5),
    .len_width_p (4)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .fifo_v_i        (fifo_v),
    .fifo_data_i     (fifo_data),
    .fifo_yumi_o     (fifo_yumi),
    .header_v_o      (header_v),
    .header_o        (header),
    .header_yumi_i   (header_yumi),
    .data_v_o        (data_v),
    .data_o          (data),
    .data_last_o     (data_last),
    .data_ready_and_i(data_ready)
`ifdef BSG_WORMHOLE_HEADER_SPLITTER_STATS_EN
    ,
    .pkt_count_o     (pkt_count)
`endif
  );

  // Header flit: tag in [31:9], length in [8:5], coordinate 3 in [4:0].
  function automatic logic [31:0] mk_hdr(input int unsigned len, input int unsigned tag);
    return (32'(tag) << 9) | (32'(len & 15) << 5) | 32'd3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic hy, input logic rdy);
    fifo_v      = v;
    fifo_data   = d;
    header_yumi = hy;
    data_ready  = rdy;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, mk_hdr(2, 1), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      tests++;
      if (fifo_yumi !== 1'b0 || header_v !== 1'b0 || data_v !== 1'b0 || data_last !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d got yumi=%b hv=%b dv=%b last=%b required 0000",
                 i, fifo_yumi, header_v, data_v, data_last);
      end
    end
    tests++;
    if (header !== 32'h0) begin
      errors++;
      $display("FAIL reset_header got %h required 00000000", header);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_packet();
    logic [31:0] h;
    logic [31:0] pay[3];
    h = mk_hdr(3, 'h11);
    pay[0] = 32'hA0A0_0001;
    pay[1] = 32'hB0B0_0002;
    pay[2] = 32'hC0C0_0003;
    drive(1'b1, h, 1'b0, 1'b1);
    tests++;
    if (fifo_yumi !== 1'b1 || data_v !== 1'b0) begin
      errors++;
      $display("FAIL basic_hdr_deq got yumi=%b dv=%b required 1 0", fifo_yumi, data_v);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      // Consume the header one cycle after it appears.
      drive(1'b1, pay[i], (i == 0), 1'b1);
      tests++;
      if (data_v !== 1'b1 || data !== pay[i] || fifo_yumi !== 1'b1 || data_last !== (i == 2)) begin
        errors++;
        $display("FAIL basic_payload%0d got dv=%b data=%h yumi=%b last=%b required 1 %h 1 %b",
                 i, data_v, data, fifo_yumi, data_last, pay[i], (i == 2));
      end
      tests++;
      if (header !== h || header_v !== (i == 0)) begin
        errors++;
        $display("FAIL basic_header%0d got hv=%b hdr=%h required %b %h",
                 i, header_v, header, (i == 0), h);
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tests++;
    if (data_v !== 1'b0 || header_v !== 1'b0 || header !== h) begin
      errors++;
      $display("FAIL basic_idle got dv=%b hv=%b hdr=%h required 0 0 %h", data_v, header_v, header, h);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] h1;
    logic [31:0] h2;
    h1 = mk_hdr(0, 'h21);
    h2 = mk_hdr(0, 'h22);
    drive(1'b1, h1, 1'b0, 1'b1);
    tests++;
    if (fifo_yumi !== 1'b1 || data_v !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got yumi=%b dv=%b required 1 0", fifo_yumi, data_v);
    end
    tick();
    drive(1'b1, h2, 1'b1, 1'b1);
    tests++;
    if (fifo_yumi !== 1'b1 || data_v !== 1'b0 || header_v !== 1'b1 || header !== h1) begin
      errors++;
      $display("FAIL b2b_second got yumi=%b dv=%b hv=%b hdr=%h required 1 0 1 %h",
               fifo_yumi, data_v, header_v, header, h1);
    end
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    tests++;
    if (header_v !== 1'b1 || header !== h2 || data_v !== 1'b0 || fifo_yumi !== 1'b0) begin
      errors++;
      $display("FAIL b2b_update got hv=%b hdr=%h dv=%b yumi=%b required 1 %h 0 0",
               header_v, header, data_v, fifo_yumi, h2);
    end
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tests++;
    if (header_v !== 1'b0) begin
      errors++;
      $display("FAIL b2b_consumed got hv=%b required 0", header_v);
    end
  endtask

  task automatic test_header_stall();
    logic [31:0] h4;
    logic [31:0] h5;
    h4 = mk_hdr(2, 'h44);
    h5 = mk_hdr(1, 'h55);
    drive(1'b1, h4, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hD400_0000 + 32'(i), 1'b0, 1'b1);
      tests++;
      if (fifo_yumi !== 1'b1 || data_v !== 1'b1 || header_v !== 1'b1 || data_last !== (i == 1)) begin
        errors++;
        $display("FAIL stall_drain%0d got yumi=%b dv=%b hv=%b last=%b required 1 1 1 %b",
                 i, fifo_yumi, data_v, header_v, data_last, (i == 1));
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, h5, 1'b0, 1'b1);
      tests++;
      if (fifo_yumi !== 1'b0 || data_v !== 1'b0 || header !== h4) begin
        errors++;
        $display("FAIL stall_hold%0d got yumi=%b dv=%b hdr=%h required 0 0 %h",
                 i, fifo_yumi, data_v, header, h4);
      end
      tick();
    end
    drive(1'b1, h5, 1'b1, 1'b1);
    tests++;
    if (fifo_yumi !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got yumi=%b required 1", fifo_yumi);
    end
    tick();
    drive(1'b1, 32'hD500_0000, 1'b0, 1'b1);
    tests++;
    if (header !== h5 || header_v !== 1'b1 || data_v !== 1'b1 || data_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_next got hdr=%h hv=%b dv=%b last=%b required %h 1 1 1",
               header, header_v, data_v, data_last, h5);
    end
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_ready_toggle();
    logic [31:0] h6;
    logic [31:0] h7;
    logic [31:0] flit;
    int          sent;
    h6 = mk_hdr(4, 'h66);
    h7 = mk_hdr(0, 'h77);
    drive(1'b1, h6, 1'b0, 1'b1);
    tick();
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      // Ready pattern 1,0,1,0,...: each payload flit offered twice except the first.
      logic rdy;
      rdy  = ((c % 2) == 0);
      flit = 32'hE600_0000 + 32'(sent);
      drive(1'b1, flit, 1'b0, rdy);
      tests++;
      if (fifo_yumi !== rdy || data_v !== 1'b1 || data !== flit || data_last !== (sent == 3)) begin
        errors++;
        $display("FAIL ready_cyc%0d got yumi=%b dv=%b data=%h last=%b required %b 1 %h %b",
                 c, fifo_yumi, data_v, data, data_last, rdy, flit, (sent == 3));
      end
      if (rdy) sent++;
      tick();
      if (sent == 4) break;
    end
    drive(1'b1, h7, 1'b1, 1'b1);
    tests++;
    if (data_v !== 1'b0 || fifo_yumi !== 1'b1) begin
      errors++;
      $display("FAIL ready_back_to_hdr got dv=%b yumi=%b required 0 1", data_v, fifo_yumi);
    end
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic [31:0] h8;
    logic [31:0] h9;
    h8 = mk_hdr(3, 'h88);
    h9 = mk_hdr(1, 'h99);
    drive(1'b1, h8, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'hF800_0000, 1'b0, 1'b1);
    tick();
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    reset_n = 1'b1;
    drive(1'b1, h9, 1'b0, 1'b1);
    tests++;
    if (header_v !== 1'b0 || data_v !== 1'b0 || fifo_yumi !== 1'b1 || header !== 32'h0) begin
      errors++;
      $display("FAIL rst_fresh got hv=%b dv=%b yumi=%b hdr=%h required 0 0 1 00000000",
               header_v, data_v, fifo_yumi, header);
    end
`ifdef BSG_WORMHOLE_HEADER_SPLITTER_STATS_EN
    tests++;
    if (pkt_count !== 16'h0) begin
      errors++;
      $display("FAIL rst_count got %h required 0000", pkt_count);
    end
`endif
    tick();
    drive(1'b1, 32'hF900_0000, 1'b1, 1'b1);
    tests++;
    if (header !== h9 || header_v !== 1'b1 || data_v !== 1'b1 || data_last !== 1'b1) begin
      errors++;
      $display("FAIL rst_new_pkt got hdr=%h hv=%b dv=%b last=%b required %h 1 1 1",
               header, header_v, data_v, data_last, h9);
    end
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tests++;
    if (header_v !== 1'b0 || data_v !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got hv=%b dv=%b required 0 0", header_v, data_v);
    end
`ifdef BSG_WORMHOLE_HEADER_SPLITTER_STATS_EN
    tests++;
    if (pkt_count !== 16'h1) begin
      errors++;
      $display("FAIL stats_one got %h required 0001", pkt_count);
    end
    // Zero-length headers complete one packet per cycle; run to 0xFFFF then wrap.
    drive(1'b1, mk_hdr(0, 'hAA), 1'b0, 1'b1);
    tick();
    drive(1'b1, mk_hdr(0, 'hAB), 1'b1, 1'b1);
    for (int i = 0; i < 65533; i++) tick();
    tests++;
    if (pkt_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_max got %h required ffff", pkt_count);
    end
    tick();
    tests++;
    if (pkt_count !== 16'h0000) begin
      errors++;
      $display("FAIL stats_wrap got %h required 0000", pkt_count);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
`endif
  endtask

  initial begin
    reset_n     = 1'b0;
    fifo_v      = 1'b0;
    fifo_data   = 32'h0;
    header_yumi = 1'b0;
    data_ready  = 1'b1;
    test_reset();
    test_basic_packet();
    test_back_to_back();
    test_header_stall();
    test_ready_toggle();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
